// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern driver.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int unsigned LED_N = 8;
  localparam logic [LED_N-1:0] SCAN_RELOAD = 8'h01;

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-step prescaler: counts 0..PRESCALE-1 while enabled, holds otherwise,
// and emits a registered one-cycle step_tick on each wrap. clr restarts the count.
module led_tick_gen #(
  parameter int unsigned PRESCALE = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step_tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign step_tick = tick_q;

endmodule

// File: rtl/led_pattern_driver.sv
// 8-channel LED pattern sequencer (static/scan/count/blink) with global PWM.
// Define LED_FADE_EN to add a quarter-brightness trail behind the SCAN dot.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE = 2500000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [LED_N-1:0]    pattern_in,
  input  logic [PWM_BITS-1:0] duty,
  output logic [LED_N-1:0]    led,
  output logic                step_tick
);

  mode_e                mode_in;
  mode_e                mode_q, mode_d;
  dir_e                 dir_q, dir_d;
  logic [LED_N-1:0]     pat_q, pat_d;
  logic [LED_N-1:0]     led_q, led_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic                 pwm_on;
  logic                 mode_chg;
  logic [LED_N-1:0]     nxt;
`ifdef LED_FADE_EN
  logic [LED_N-1:0]     trail_q, trail_d;
  logic                 pwm_dim;
`endif

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);

  led_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (mode_chg),
    .step_tick(step_tick)
  );

  // Free-running PWM; all-ones duty is treated as fully on rather than 255/256.
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  assign pwm_on    = (duty == '1) || (pwm_cnt_q < duty);
`ifdef LED_FADE_EN
  assign pwm_dim   = (pwm_cnt_q < (duty >> 2));
`endif

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    nxt    = '0;
    if (mode_chg) begin
      mode_d = mode_in;
      dir_d  = DIR_LEFT;
      unique case (mode_in)
        MODE_SCAN:  pat_d = SCAN_RELOAD;
        MODE_COUNT: pat_d = '0;
        default:    pat_d = pattern_in;
      endcase
    end else begin
      unique case (mode_q)
        MODE_STATIC: pat_d = pattern_in;
        MODE_SCAN: begin
          if (step_tick) begin
            if (!$onehot(pat_q)) begin
              pat_d = SCAN_RELOAD;
              dir_d = DIR_LEFT;
            end else if (dir_q == DIR_LEFT) begin
              nxt   = pat_q << 1;
              pat_d = nxt;
              if (nxt == 8'h80) dir_d = DIR_RIGHT;
            end else begin
              nxt   = pat_q >> 1;
              pat_d = nxt;
              if (nxt == 8'h01) dir_d = DIR_LEFT;
            end
          end
        end
        MODE_COUNT: if (step_tick) pat_d = pat_q + 8'd1;
        MODE_BLINK: if (step_tick) pat_d = (pat_q == '0) ? pattern_in : '0;
        default: pat_d = pat_q;
      endcase
    end
  end

`ifdef LED_FADE_EN
  always_comb begin
    trail_d = trail_q;
    if (mode_chg || mode_q != MODE_SCAN) trail_d = '0;
    else if (step_tick)                  trail_d = pat_q;
  end

  assign led_d = (pat_q & {LED_N{pwm_on}}) | (trail_q & ~pat_q & {LED_N{pwm_dim}});
`else
  assign led_d = pat_q & {LED_N{pwm_on}};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_STATIC;
      dir_q     <= DIR_LEFT;
      pat_q     <= '0;
      led_q     <= '0;
      pwm_cnt_q <= '0;
`ifdef LED_FADE_EN
      trail_q   <= '0;
`endif
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pat_q     <= pat_d;
      led_q     <= led_d;
      pwm_cnt_q <= pwm_cnt_d;
`ifdef LED_FADE_EN
      trail_q   <= trail_d;
`endif
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver with PRESCALE=4.
module tb_led_pattern_driver;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] pattern_in;
  logic [7:0] duty;
  logic [7:0] led;
  logic       step_tick;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned bit_on [8];
  int unsigned stray;

`ifdef LED_FADE_EN
  localparam int unsigned TRAIL_ON = 32;
`else
  localparam int unsigned TRAIL_ON = 0;
`endif

  led_pattern_driver #(
    .PRESCALE(4),
    .PWM_BITS(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .pattern_in(pattern_in),
    .duty      (duty),
    .led       (led),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int unsigned n = 0;
    while (step_tick !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    check("tick_arrives", {31'd0, step_tick}, 32'd1);
  endtask

  // Samples 256 consecutive cycles: per-bit on counts, and cycles with bits outside mask.
  task automatic measure(input logic [7:0] mask);
    for (int b = 0; b < 8; b++) bit_on[b] = 0;
    stray = 0;
    for (int c = 0; c < 256; c++) begin
      step(1);
      for (int b = 0; b < 8; b++) if (led[b]) bit_on[b]++;
      if ((led & ~mask) != 8'h00) stray++;
    end
  endtask

  logic [7:0] scan_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] blink_exp [4] = '{8'h00, 8'h0F, 8'h00, 8'h0F};

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd0; pattern_in = 8'h00; duty = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", {24'd0, led}, 32'h00);
    check("reset_tick", {31'd0, step_tick}, 32'd0);

    // STATIC: two-cycle latency from pattern_in to led
    rst = 1'b0; pattern_in = 8'hA5;
    step(1);
    check("static_lat1", {24'd0, led}, 32'h00);
    step(1);
    check("static_lat2", {24'd0, led}, 32'hA5);

    wait_tick();
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check("tick_gap", {31'd0, step_tick}, 32'd0);
    end
    step(1);
    check("tick_period", {31'd0, step_tick}, 32'd1);

    // SCAN: bounce with end bits not repeated
    mode = 2'd1;
    step(2);
    check("scan_reload", {24'd0, led}, 32'h01);
    for (int i = 0; i < 15; i++) begin
      wait_tick();
      step(2);
      check($sformatf("scan_%0d", i), {24'd0, led}, {24'd0, scan_exp[i]});
    end

    // COUNT: full wrap, then freeze with en low
    mode = 2'd2;
    step(2);
    check("count_reload", {24'd0, led}, 32'h00);
    for (int i = 1; i <= 257; i++) begin
      wait_tick();
      step(2);
      check($sformatf("count_%0d", i), {24'd0, led}, i & 32'hFF);
    end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("freeze_led", {24'd0, led}, 32'h01);
      check("freeze_tick", {31'd0, step_tick}, 32'd0);
    end
    en = 1'b1;

    // BLINK and PWM duty
    mode = 2'd3; pattern_in = 8'h0F;
    step(2);
    check("blink_reload", {24'd0, led}, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      step(2);
      check($sformatf("blink_%0d", i), {24'd0, led}, {24'd0, blink_exp[i]});
    end
    en = 1'b0; duty = 8'h40;
    step(2);
    measure(8'h0F);
    check("duty40_bit0", bit_on[0], 32'd64);
    check("duty40_bit3", bit_on[3], 32'd64);
    check("duty40_stray", stray, 32'd0);
    duty = 8'h00;
    step(2);
    measure(8'h00);
    check("duty0_bit0", bit_on[0], 32'd0);
    check("duty0_stray", stray, 32'd0);

    // Asynchronous reset mid-SCAN, then mode change coinciding with a tick
    en = 1'b1; duty = 8'hFF; mode = 2'd1;
    step(2);
    check("scan2_reload", {24'd0, led}, 32'h01);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      step(2);
    end
    check("scan2_at10", {24'd0, led}, 32'h10);
    #3 rst = 1'b1;
    #1;
    check("async_rst_led", {24'd0, led}, 32'h00);
    check("async_rst_tick", {31'd0, step_tick}, 32'd0);
    mode = 2'd0; pattern_in = 8'h3C;
    step(2);
    check("rst_hold_led", {24'd0, led}, 32'h00);
    rst = 1'b0;
    step(2);
    check("post_rst_static", {24'd0, led}, 32'h3C);
    wait_tick();
    mode = 2'd1;
    step(2);
    check("chg_on_tick", {24'd0, led}, 32'h01);
    wait_tick();
    step(2);
    check("chg_on_tick_next", {24'd0, led}, 32'h02);

    // Trail brightness (zero without the fade option)
    duty = 8'h80; mode = 2'd0;
    step(2);
    mode = 2'd1;
    step(2);
    wait_tick();
    step(2);
    wait_tick();
    step(2);
    en = 1'b0;
    step(2);
    measure(8'h06);
    check("fade_cur", bit_on[2], 32'd128);
    check("fade_prev", bit_on[1], TRAIL_ON);
    check("fade_stray", stray, 32'd0);
    mode = 2'd2;
    step(2);
    measure(8'h00);
    check("count_no_trail", stray, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
